// File: rtl/dm_sram_resp_pkg.sv
// dm_sram_pkg: shared definitions for the data-memory responder.
//   - size encodings SZ_BYTE / SZ_HALF / SZ_WORD (2'b11 decodes as word)
//   - size_to_be(): byte-lane enables from access size and addr[1:0]
//   - LFSR seed/taps for the optional random back-pressure
//     (DM_SRAM_RAND_STALL_EN)
//   - head_state_e: responder head FSM states
//   - dm_entry_t: one queued request {wr, be, word index, wdata, cnt}
package dm_sram_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Word index is held at its widest legal size; the top uses the low
    // ADDR_W-2 bits.
    localparam int IDX_MAX_W = 30;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1 in right-shift form: the new
    // MSB is the XOR of bits 0,2,3,5.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        HS_EMPTY,
        HS_WAIT,
        HS_RESP
    } head_state_e;

    typedef struct packed {
        logic                 wr;
        logic [3:0]           be;
        logic [IDX_MAX_W-1:0] idx;
        logic [31:0]          wdata;
        logic [3:0]           cnt;
    } dm_entry_t;

    // Misaligned halves/words simply drop the low address bits; the
    // address-error exception is raised upstream.
    function automatic logic [3:0] size_to_be(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 4'b0001 << addr_lo;
            SZ_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dm_sram_resp_if.sv
// dm_sram_resp_if: SRAM-like data port between the MEM stage and the
// data-memory responder.
//   req/wr/size/addr/wdata : request, held stable by the master until addr_ok
//   addr_ok                : request accepted this cycle
//   data_ok/rdata          : one-cycle completion pulse and aligned read word
interface dm_sram_resp_if #(
    parameter int ADDR_W = 13
) ();
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [31:0]       rdata;

    modport master (output req, wr, size, addr, wdata,
                    input  addr_ok, data_ok, rdata);
    modport slave  (input  req, wr, size, addr, wdata,
                    output addr_ok, data_ok, rdata);
endinterface

// File: rtl/dm_sram_resp_req_fifo.sv
// dm_req_fifo: DEPTH-entry in-order request queue with a per-entry latency
// countdown.
//   clk, rst           : clock, synchronous active-high reset
//   push, push_entry   : enqueue (caller guarantees count < DEPTH)
//   pop                : dequeue head (caller guarantees head_valid)
//   count              : occupancy, 0..DEPTH
//   head_valid/ready   : head present / head countdown expired
//   head               : head entry
//   next_valid/ready   : second entry present / its countdown expired
//   next_entry         : second entry, lets the responder issue back-to-back
module dm_req_fifo
    import dm_sram_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  dm_entry_t push_entry,
    input  logic      pop,
    output logic [PW:0] count,
    output logic      head_valid,
    output logic      head_ready,
    output dm_entry_t head,
    output logic      next_valid,
    output logic      next_ready,
    output dm_entry_t next_entry
);
    dm_entry_t     mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, nx_ptr;

    assign nx_ptr     = rd_ptr + 1'b1;
    assign head       = mem[rd_ptr];
    assign next_entry = mem[nx_ptr];
    assign head_valid = (count != '0);
    assign next_valid = (count > (PW+1)'(1));
    assign head_ready = (head.cnt == 4'd0);
    assign next_ready = (next_entry.cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // Free slots may also count down; they are overwritten on push.
            for (int i = 0; i < DEPTH; i++)
                if (mem[i].cnt != 4'd0)
                    mem[i].cnt <= mem[i].cnt - 4'd1;
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: rtl/dm_sram_resp.sv
// dm_sram_resp: variable-latency data-memory responder for the MEM stage.
// Accepts up to DEPTH outstanding reads/writes and completes them in order,
// no earlier than LATENCY cycles after acceptance.
//   clk  : clock
//   rst  : synchronous active-high reset (discards queued requests)
//   bus  : dm_sram_resp_if.slave (req/wr/size/addr/wdata, addr_ok,
//          data_ok, rdata)
// Optional: `define DM_SRAM_RAND_STALL_EN gates addr_ok with a 16-bit LFSR
// for pseudo-random back-pressure; the data path is unchanged.
module dm_sram_resp
    import dm_sram_pkg::*;
#(
    parameter int ADDR_W  = 13,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 2
) (
    input logic           clk,
    input logic           rst,
    dm_sram_resp_if.slave bus
);
    localparam int PW    = $clog2(DEPTH);
    localparam int IDX_W = ADDR_W - 2;
    localparam int WORDS = 1 << IDX_W;

    logic [31:0] ram [WORDS];

    logic [PW:0] count;
    logic        head_valid, head_ready, next_valid, next_ready;
    dm_entry_t   head, next_entry, push_entry, sel;
    head_state_e state;
    logic        push, pop, start_resp, stall, data_ok_q;
    logic [31:0] rdata_q, rd_word;

`ifdef DM_SRAM_RAND_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    end
    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    // Registered count: a slot retiring this cycle does not free space
    // until the next one.
    assign bus.addr_ok = bus.req & ~rst & (count < (PW+1)'(DEPTH)) & ~stall;
    assign push        = bus.addr_ok;
    assign pop         = (state == HS_RESP);
    assign bus.data_ok = data_ok_q;
    assign bus.rdata   = rdata_q;

    always_comb begin
        push_entry       = '0;
        push_entry.wr    = bus.wr;
        push_entry.be    = size_to_be(bus.size, bus.addr[1:0]);
        push_entry.idx   = IDX_MAX_W'(bus.addr[ADDR_W-1:2]);
        push_entry.wdata = bus.wdata;
        push_entry.cnt   = 4'(LATENCY - 1);
    end

    dm_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .count     (count),
        .head_valid(head_valid),
        .head_ready(head_ready),
        .head      (head),
        .next_valid(next_valid),
        .next_ready(next_ready),
        .next_entry(next_entry)
    );

    // While responding, the head is popped at this edge, so the entry that
    // may respond next is the second one. Going RESP->RESP directly keeps
    // completions gap-free when the follower is already due. A write being
    // retired in the same edge is merged into the read word so a read right
    // behind a write to the same word sees post-write data.
    always_comb begin
        sel        = (state == HS_RESP) ? next_entry : head;
        start_resp = (state == HS_RESP) ? (next_valid & next_ready)
                                        : (head_valid & head_ready);
        rd_word    = ram[sel.idx[IDX_W-1:0]];
        if (state == HS_RESP && head.wr && head.idx == sel.idx)
            for (int b = 0; b < 4; b++)
                if (head.be[b]) rd_word[8*b +: 8] = head.wdata[8*b +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HS_EMPTY;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            data_ok_q <= start_resp;
            rdata_q   <= (start_resp && !sel.wr) ? rd_word : 32'h0;
            if (start_resp)
                state <= HS_RESP;
            else if ((state == HS_RESP) ? next_valid : head_valid)
                state <= HS_WAIT;
            else
                state <= HS_EMPTY;
        end
    end

    // Writes commit on the data_ok edge; reset drops anything still queued.
    always_ff @(posedge clk) begin
        if (!rst && pop && head.wr)
            for (int b = 0; b < 4; b++)
                if (head.be[b])
                    ram[head.idx[IDX_W-1:0]][8*b +: 8] <= head.wdata[8*b +: 8];
    end
endmodule
